// File: rtl/relm_ps2_sync.sv
// Two-flop synchronizer for an idle-high PS/2 line.
// Resets to 1 so a released bus reads as idle straight out of reset.
module relm_ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/relm_ps2_dev.sv
// PS/2 device-side controller: one-byte tx holding register, one-entry rx buffer,
// device-generated clock, host inhibit/abort handling and request-to-send receive.
//
// state | meaning
// IDLE  | lines released, waiting for host request-to-send or a pending tx byte
// TX    | sending 11-slot frame (start, 8 data, odd parity, stop)
// RX    | clocking in 10 slots from host (8 data, parity, stop)
// ACK   | one extra slot with data pulled low to acknowledge the host
// HOLD  | lines released, waiting for clk high for 2*HALF cycles
module relm_ps2_dev #(
    parameter int WD   = 32,
    parameter int HALF = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [WD:0] tx_d,
    output logic        tx_retry,
    input  logic [WD:0] rx_d,
    output logic [WD:0] rx_q,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe
);

    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);
    // Post-frame settle covers synchronizer lag after we release the data line.
    localparam logic [CW-1:0] SETTLE = CW'(2);
    localparam logic [3:0] TX_LAST = 4'd10;
    localparam logic [3:0] RX_LAST = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_RX   = 3'd2,
        S_ACK  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    logic sclk, sdat;

    relm_ps2_sync u_sync_clk (.clk(clk), .rst_n(rst_n), .d(ps2_clk_in), .q(sclk));
    relm_ps2_sync u_sync_dat (.clk(clk), .rst_n(rst_n), .d(ps2_dat_in), .q(sdat));

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    slot, slot_nx, slot_inc;
    logic          hi, hi_nx;
    logic [9:0]    shreg, shreg_nx;
    logic          clk_oe_r, clk_oe_nx;
    logic          dat_oe_r, dat_oe_nx;
    logic          boot, boot_nx;
    logic          store, tx_done, half_end;

    logic          tx_full;
    logic [7:0]    tx_byte;
    logic [10:0]   tx_frame;

    logic          rx_valid, rx_perr, rx_ovr, pop;
    logic [7:0]    rx_byte;

    logic          unused_bits;

    assign unused_bits = ^{tx_d[WD-1:8], rx_d[WD-1:0]};

    assign tx_frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign half_end = (cnt == '0);
    assign slot_inc = slot + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            slot     <= '0;
            hi       <= 1'b0;
            shreg    <= '0;
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            boot     <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            slot     <= slot_nx;
            hi       <= hi_nx;
            shreg    <= shreg_nx;
            clk_oe_r <= clk_oe_nx;
            dat_oe_r <= dat_oe_nx;
            boot     <= boot_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        slot_nx   = slot;
        hi_nx     = hi;
        shreg_nx  = shreg;
        clk_oe_nx = clk_oe_r;
        dat_oe_nx = dat_oe_r;
        boot_nx   = boot;
        store     = 1'b0;
        tx_done   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!half_end) begin
                    cnt_nx = cnt - CW'(1);
                end else if (boot) begin
                    boot_nx  = 1'b0;
                    state_nx = S_HOLD;
                    cnt_nx   = RELOAD;
                    hi_nx    = 1'b0;
                end else if (sclk && !sdat) begin
                    state_nx  = S_RX;
                    slot_nx   = '0;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b1;
                    dat_oe_nx = 1'b0;
                end else if (tx_full && sclk && sdat) begin
                    state_nx  = S_TX;
                    slot_nx   = '0;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b1;
                    dat_oe_nx = ~tx_frame[0];
                end
            end

            S_TX: begin
                if (!half_end) begin
                    cnt_nx = cnt - CW'(1);
                end else if (!hi) begin
                    hi_nx     = 1'b1;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b0;
                end else if (slot == TX_LAST) begin
                    tx_done   = 1'b1;
                    state_nx  = S_IDLE;
                    hi_nx     = 1'b0;
                    cnt_nx    = SETTLE;
                    dat_oe_nx = 1'b0;
                end else if (!sclk) begin
                    // Host is holding clock low: give up the frame, keep the byte.
                    state_nx  = S_HOLD;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b0;
                    dat_oe_nx = 1'b0;
                end else begin
                    slot_nx   = slot_inc;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b1;
                    dat_oe_nx = ~tx_frame[slot_inc];
                end
            end

            S_RX: begin
                if (!half_end) begin
                    cnt_nx = cnt - CW'(1);
                end else if (!hi) begin
                    shreg_nx[slot] = sdat;
                    hi_nx          = 1'b1;
                    cnt_nx         = RELOAD;
                    clk_oe_nx      = 1'b0;
                end else if (slot == RX_LAST) begin
                    store     = 1'b1;
                    state_nx  = S_ACK;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b1;
                    dat_oe_nx = 1'b1;
                end else begin
                    slot_nx   = slot_inc;
                    hi_nx     = 1'b0;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b1;
                end
            end

            S_ACK: begin
                if (!half_end) begin
                    cnt_nx = cnt - CW'(1);
                end else if (!hi) begin
                    hi_nx     = 1'b1;
                    cnt_nx    = RELOAD;
                    clk_oe_nx = 1'b0;
                end else begin
                    state_nx  = S_IDLE;
                    hi_nx     = 1'b0;
                    cnt_nx    = SETTLE;
                    dat_oe_nx = 1'b0;
                end
            end

            S_HOLD: begin
                // hi marks the second half of the 2*HALF high window.
                if (!sclk) begin
                    cnt_nx = RELOAD;
                    hi_nx  = 1'b0;
                end else if (!half_end) begin
                    cnt_nx = cnt - CW'(1);
                end else if (!hi) begin
                    hi_nx  = 1'b1;
                    cnt_nx = RELOAD;
                end else begin
                    state_nx = S_IDLE;
                    hi_nx    = 1'b0;
                    cnt_nx   = '0;
                end
            end

            default: begin
                state_nx  = S_IDLE;
                cnt_nx    = '0;
                clk_oe_nx = 1'b0;
                dat_oe_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_byte <= '0;
        end else if (tx_done) begin
            tx_full <= 1'b0;
        end else if (tx_d[WD] && !tx_full) begin
            tx_full <= 1'b1;
            tx_byte <= tx_d[7:0];
        end
    end

    assign pop = rx_d[WD] && rx_valid;

    // A store in the same cycle as a pop replaces the entry cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_perr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else if (store) begin
            if (rx_valid && !pop) begin
                rx_ovr <= 1'b1;
            end else begin
                rx_valid <= 1'b1;
                rx_byte  <= shreg[7:0];
                rx_perr  <= ~(^shreg[8:0]) | ~shreg[9];
                rx_ovr   <= 1'b0;
            end
        end else if (pop) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_perr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end
    end

    assign rx_q       = {~rx_valid, {(WD-10){1'b0}}, rx_ovr, rx_perr, rx_byte};
    assign tx_retry   = tx_full;
    assign ps2_clk_oe = clk_oe_r;
    assign ps2_dat_oe = dat_oe_r;

endmodule

// File: tb/tb_relm_ps2_dev.sv
// Directed bench for relm_ps2_dev with HALF=4 and an open-drain host model on both lines.
module tb_relm_ps2_dev;

    localparam int WD   = 32;
    localparam int HALF = 4;
    localparam logic [WD:0] RX_EMPTY = {1'b1, {WD{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WD:0]   tx_d = '0;
    logic [WD:0]   rx_d = '0;
    logic          tx_retry;
    logic [WD:0]   rx_q;
    logic          ps2_clk_oe, ps2_dat_oe;
    logic          host_clk_low = 1'b0;
    logic          host_dat_low = 1'b0;
    logic          clk_line, dat_line;

    int total = 0;
    int bad   = 0;
    int rises = 0;

    assign clk_line = ~(ps2_clk_oe | host_clk_low);
    assign dat_line = ~(ps2_dat_oe | host_dat_low);

    relm_ps2_dev #(.WD(WD), .HALF(HALF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_d       (tx_d),
        .tx_retry   (tx_retry),
        .rx_d       (rx_d),
        .rx_q       (rx_q),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    always @(posedge ps2_clk_oe) rises++;

    task automatic wait_rises(input int target, output logic tmo);
        int n;
        n = 0;
        while (rises < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        tmo = (rises < target);
    endtask

    // Records the line-level data bit at the start of each device clock-low.
    task automatic capture_tx(input int base, output logic [10:0] fr, output int pulses);
        logic tmo;
        fr = '0;
        pulses = 0;
        for (int k = 0; k < 11; k++) begin
            wait_rises(base + k + 1, tmo);
            if (tmo) break;
            fr[k] = dat_line;
            pulses++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_d = {1'b1, {(WD-8){1'b0}}, b};
    endtask

    task automatic host_send(input logic [7:0] b, input logic par, input logic stp,
                             input logic pop_at_store, output logic ack, output logic tmo);
        logic [9:0] bits;
        int base, n;
        bits = {stp, par, b};
        ack = 1'b0;
        tmo = 1'b0;
        host_clk_low = 1'b1;
        repeat (4) @(negedge clk);
        host_dat_low = 1'b1;
        repeat (4) @(negedge clk);
        base = rises;
        host_clk_low = 1'b0;
        for (int s = 0; s < 11; s++) begin
            wait_rises(base + s + 1, tmo);
            if (tmo) break;
            if (s < 10) begin
                host_dat_low = ~bits[s];
            end else begin
                host_dat_low = 1'b0;
                rx_d = '0;
                ack = ps2_dat_oe;
            end
            if (s == 9 && pop_at_store) begin
                n = 0;
                while (ps2_clk_oe !== 1'b0 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                // Stop slot high half is HALF cycles; the store edge follows the 3rd negedge.
                repeat (3) @(negedge clk);
                rx_d = {1'b1, {WD{1'b0}}};
            end
        end
        host_dat_low = 1'b0;
        n = 0;
        while (ps2_dat_oe !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_pop();
        @(negedge clk);
        rx_d = {1'b1, {WD{1'b0}}};
        @(negedge clk);
        rx_d = '0;
    endtask

    task automatic test_reset();
        int base, n, pulses;
        logic [10:0] fr;
        repeat (3) @(negedge clk);
        total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
        total++; if (ps2_dat_oe !== 1'b0) begin bad++; $display("FAIL reset_dat_oe got %b want 0", ps2_dat_oe); end
        total++; if (tx_retry !== 1'b0) begin bad++; $display("FAIL reset_tx_retry got %b want 0", tx_retry); end
        total++; if (rx_q !== RX_EMPTY) begin bad++; $display("FAIL reset_rx_q got %h want %h", rx_q, RX_EMPTY); end
        // Push in the release cycle: first pulse must wait out the 2*HALF hold.
        base = rises;
        rst_n = 1'b1;
        push(8'h00);
        @(negedge clk);
        tx_d = '0;
        n = 1;
        while (rises == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != 2*HALF + 2) begin bad++; $display("FAIL boot_hold_delay got %0d want %0d", n, 2*HALF + 2); end
        capture_tx(base, fr, pulses);
        total++; if (pulses != 11) begin bad++; $display("FAIL boot_tx_pulses got %0d want 11", pulses); end
        total++; if (fr !== 11'b1_1_00000000_0) begin bad++; $display("FAIL boot_tx_frame got %b want %b", fr, 11'b1_1_00000000_0); end
        n = 0;
        while (tx_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (tx_retry !== 1'b0) begin bad++; $display("FAIL boot_tx_retry got %b want 0", tx_retry); end
    endtask

    task automatic test_tx();
        int base, n, pulses;
        logic [10:0] fr;
        repeat (5) @(negedge clk);
        base = rises;
        push(8'h1C);
        @(negedge clk);
        total++; if (tx_retry !== 1'b1) begin bad++; $display("FAIL tx_accept got %b want 1", tx_retry); end
        push(8'hFF);
        @(negedge clk);
        tx_d = '0;
        capture_tx(base, fr, pulses);
        total++; if (pulses != 11) begin bad++; $display("FAIL tx_pulses got %0d want 11", pulses); end
        total++; if (fr !== 11'b1_0_00011100_0) begin bad++; $display("FAIL tx_frame got %b want %b", fr, 11'b1_0_00011100_0); end
        total++; if (tx_retry !== 1'b1) begin bad++; $display("FAIL tx_retry_in_stop got %b want 1", tx_retry); end
        n = 0;
        while (tx_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != 2*HALF) begin bad++; $display("FAIL tx_retry_release got %0d want %0d", n, 2*HALF); end
        repeat (10) @(negedge clk);
        total++; if (rises != base + 11) begin bad++; $display("FAIL tx_extra_pulse got %0d want %0d", rises - base, 11); end
    endtask

    task automatic test_rx_basic();
        logic ack, tmo;
        host_send(8'hF0, 1'b1, 1'b1, 1'b0, ack, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rx_timeout got %b want 0", tmo); end
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rx_ack got %b want 1", ack); end
        repeat (4) @(negedge clk);
        total++; if (rx_q !== 33'h0_0000_00F0) begin bad++; $display("FAIL rx_byte got %h want %h", rx_q, 33'h0_0000_00F0); end
        do_pop();
        total++; if (rx_q !== RX_EMPTY) begin bad++; $display("FAIL rx_pop got %h want %h", rx_q, RX_EMPTY); end
    endtask

    task automatic test_overrun();
        logic ack, tmo;
        host_send(8'hED, 1'b1, 1'b1, 1'b0, ack, tmo);
        host_send(8'h02, 1'b0, 1'b1, 1'b0, ack, tmo);
        repeat (4) @(negedge clk);
        total++; if (rx_q !== 33'h0_0000_02ED) begin bad++; $display("FAIL overrun_q got %h want %h", rx_q, 33'h0_0000_02ED); end
        do_pop();
        total++; if (rx_q !== RX_EMPTY) begin bad++; $display("FAIL overrun_pop got %h want %h", rx_q, RX_EMPTY); end
    endtask

    task automatic test_perr();
        logic ack, tmo;
        host_send(8'h01, 1'b1, 1'b1, 1'b0, ack, tmo);
        repeat (4) @(negedge clk);
        total++; if (rx_q !== 33'h0_0000_0101) begin bad++; $display("FAIL perr_parity got %h want %h", rx_q, 33'h0_0000_0101); end
        do_pop();
        host_send(8'h03, 1'b1, 1'b0, 1'b0, ack, tmo);
        repeat (4) @(negedge clk);
        total++; if (rx_q !== 33'h0_0000_0103) begin bad++; $display("FAIL perr_stop got %h want %h", rx_q, 33'h0_0000_0103); end
        do_pop();
    endtask

    task automatic test_pop_store();
        logic ack, tmo;
        host_send(8'h44, 1'b1, 1'b1, 1'b0, ack, tmo);
        host_send(8'h81, 1'b1, 1'b1, 1'b1, ack, tmo);
        repeat (4) @(negedge clk);
        total++; if (rx_q !== 33'h0_0000_0081) begin bad++; $display("FAIL pop_store got %h want %h", rx_q, 33'h0_0000_0081); end
        do_pop();
        total++; if (rx_q !== RX_EMPTY) begin bad++; $display("FAIL pop_store_empty got %h want %h", rx_q, RX_EMPTY); end
    endtask

    task automatic test_inhibit();
        int base, n, pulses;
        logic tmo;
        logic [10:0] fr;
        repeat (5) @(negedge clk);
        base = rises;
        push(8'h55);
        @(negedge clk);
        tx_d = '0;
        wait_rises(base + 5, tmo);
        host_clk_low = 1'b1;
        repeat (12) @(negedge clk);
        total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            bad++; $display("FAIL inhibit_release got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe);
        end
        total++; if (tx_retry !== 1'b1) begin bad++; $display("FAIL inhibit_keep got %b want 1", tx_retry); end
        repeat (8) @(negedge clk);
        base = rises;
        host_clk_low = 1'b0;
        // Two synchronizer cycles, 2*HALF high cycles, then one IDLE decision cycle.
        n = 0;
        while (rises == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != 2*HALF + 3) begin bad++; $display("FAIL inhibit_resume got %0d want %0d", n, 2*HALF + 3); end
        capture_tx(base, fr, pulses);
        total++; if (pulses != 11) begin bad++; $display("FAIL inhibit_pulses got %0d want 11", pulses); end
        total++; if (fr !== 11'b1_1_01010101_0) begin bad++; $display("FAIL inhibit_frame got %b want %b", fr, 11'b1_1_01010101_0); end
        n = 0;
        while (tx_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_rts_priority();
        int base, n, pulses;
        logic ack, tmo;
        logic [10:0] fr;
        host_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h7E);
        @(negedge clk);
        tx_d = '0;
        host_send(8'h12, 1'b1, 1'b1, 1'b0, ack, tmo);
        base = rises;
        total++; if (rx_q !== 33'h0_0000_0012) begin bad++; $display("FAIL rts_rx got %h want %h", rx_q, 33'h0_0000_0012); end
        capture_tx(base, fr, pulses);
        total++; if (pulses != 11 || fr !== 11'b1_1_01111110_0) begin
            bad++; $display("FAIL rts_tx_after got %0d/%b want 11/%b", pulses, fr, 11'b1_1_01111110_0);
        end
        n = 0;
        while (tx_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        do_pop();
    endtask

    task automatic test_reset_mid_tx();
        int base, pulses;
        logic ack, tmo;
        host_send(8'h21, 1'b1, 1'b1, 1'b0, ack, tmo);
        repeat (5) @(negedge clk);
        base = rises;
        push(8'hAA);
        @(negedge clk);
        tx_d = '0;
        wait_rises(base + 2, tmo);
        total++; if (ps2_dat_oe !== 1'b1) begin bad++; $display("FAIL mid_tx_bit0 got %b want 1", ps2_dat_oe); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            bad++; $display("FAIL async_reset_oe got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe);
        end
        total++; if (tx_retry !== 1'b0) begin bad++; $display("FAIL async_reset_retry got %b want 0", tx_retry); end
        total++; if (rx_q !== RX_EMPTY) begin bad++; $display("FAIL async_reset_rx got %h want %h", rx_q, RX_EMPTY); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = rises;
        repeat (30) @(negedge clk);
        total++; if (rises != pulses) begin bad++; $display("FAIL post_reset_clocks got %0d want 0", rises - pulses); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_basic();
        test_overrun();
        test_perr();
        test_pop_store();
        test_inhibit();
        test_rts_priority();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relm_ps2_dev.md
RELM_PS2_DEV -- requirements
Module: relm_ps2_dev

Interface
REQ-001 Parameter WD, default 32, width of the push/pop port payload (port width WD+1, bit WD = strobe/retry).
REQ-002 Parameter HALF, default 2000, PS/2 clock half-period in clk cycles (12.5 kHz at 50 MHz).
REQ-003 Port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port tx_d  input  WD+1  push port: bit WD = write strobe, [7:0] = byte to send to host.
REQ-006 Port tx_retry  output  1  1 = tx holding register full, write ignored.
REQ-007 Port rx_d  input  WD+1  pop port: bit WD = pop strobe, other bits ignored.
REQ-008 Port rx_q  output  WD+1  {empty, zeros, overrun[9], perr[8], byte[7:0]}.
REQ-009 Ports ps2_clk_in, ps2_dat_in  input  1 each  raw open-drain line levels.
REQ-010 Ports ps2_clk_oe, ps2_dat_oe  output  1 each  1 = pull line low, 0 = release.

Function
REQ-011 ps2_clk_in and ps2_dat_in SHALL each pass a 2-flop synchronizer; all decisions use synchronized values.
REQ-012 Write accepted when tx_d[WD]=1 and tx_retry=0; byte latched, tx_retry=1 next cycle.
REQ-013 tx_retry SHALL return to 0 the cycle after the stop bit of that byte completes.
REQ-014 FSM states: IDLE, TX, RX, ACK, HOLD.
REQ-015 IDLE->RX when sync clk=1 and sync dat=0 (host request-to-send); this has priority over a pending tx byte.
REQ-016 IDLE->TX when tx byte pending, sync clk=1, sync dat=1.
REQ-017 Every bit slot SHALL be: data set while clk released, HALF cycles clk_oe=1, HALF cycles clk_oe=0.
REQ-018 TX frame: 11 slots: start 0, data[0..7] LSB first, odd parity, stop 1; dat_oe = ~bit.
REQ-019 In TX, at end of each high half before slot 10, if sync clk=0 (host inhibit) SHALL abort: release both lines, keep byte, go HOLD.
REQ-020 HOLD->IDLE after sync clk has been 1 for 2*HALF consecutive cycles.
REQ-021 RX: 10 slots (data[0..7], parity, stop), device samples sync dat at clk_oe 1->0 transition (rising edge).
REQ-022 ACK: one further slot with dat_oe=1 during its low and high halves, then release and return to IDLE.
REQ-023 perr = 1 when received parity not odd or stop=0; byte still stored.
REQ-024 Received byte written to rx buffer (1 entry) at ACK start; if buffer full, new byte dropped and overrun set on the stored entry.
REQ-025 rx_q[WD] = 1 when buffer empty; pop with rx_d[WD]=1 and non-empty clears buffer and flags next cycle.
REQ-026 Simultaneous pop and RX store in same cycle: store wins, no overrun.
REQ-027 Half-period counter SHALL be ceil(log2(HALF+1)) bits, reload HALF-1, no wrap beyond.

Reset
REQ-028 On rst_n=0 (any state, mid-frame included): FSM=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_retry=0, rx_q[WD]=1, rx_q[WD-1:0]=0, counters 0, synchronizers 1.
REQ-029 First action after rst_n release SHALL wait for sync clk=1 for 2*HALF cycles (enter via HOLD).

Structure
REQ-030 No shared package; FSM encoding and frame lengths are localparams in the module.
REQ-031 One sub-module relm_ps2_sync (2-flop synchronizer, reset value 1), instantiated twice.

Verification (HALF=4)
REQ-032 Push 0x1C -> 11 clk pulses, dat sequence 0,0,0,1,1,1,0,0,0,0(parity),1; tx_retry=0 after stop.
REQ-033 Host RTS sending 0xF0 with odd parity -> rx_q = {0,...,0,0,0xF0}, ack low during 11th slot.
REQ-034 Host pulls clk low during data bit 3 of 0x55 -> lines released, after clk high 8 cycles full frame of 0x55 resent.
REQ-035 Two host bytes 0xED, 0x02 without pop -> rx_q byte=0xED, overrun=1; pop -> rx_q[WD]=1.
REQ-036 Host byte with even parity (0x01, parity 1) -> perr=1, byte=0x01.
REQ-037 rst_n pulsed low mid-TX -> oe outputs 0 asynchronously, tx_retry=0, no further clocks for 8 cycles.
